// File: rtl/rib_rr_if.sv
// Bundle of the rib_rr master-side and slave-side bus signals.
// The m_err_o wire exists only when RIB_ERR_EN is defined.
interface rib_rr_if #(
    parameter int NUM_MASTERS = 3,
    parameter int NUM_SLAVES  = 4,
    parameter int DATA_W      = 32
);
    logic [NUM_MASTERS-1:0]        m_req_i;
    logic [NUM_MASTERS-1:0]        m_we_i;
    logic [NUM_MASTERS*32-1:0]     m_addr_i;
    logic [NUM_MASTERS*DATA_W-1:0] m_wdata_i;
    logic [DATA_W-1:0]             m_rdata_o;
    logic [NUM_MASTERS-1:0]        m_ack_o;
    logic [NUM_MASTERS-1:0]        m_hold_o;
    logic [NUM_SLAVES-1:0]         s_we_o;
    logic [31:0]                   s_addr_o;
    logic [DATA_W-1:0]             s_wdata_o;
    logic [NUM_SLAVES*DATA_W-1:0]  s_rdata_i;
`ifdef RIB_ERR_EN
    logic [NUM_MASTERS-1:0]        m_err_o;
`endif

    // Interconnect view: takes master requests and slave read data.
    modport slave (
        input  m_req_i, m_we_i, m_addr_i, m_wdata_i, s_rdata_i,
        output m_rdata_o, m_ack_o, m_hold_o, s_we_o, s_addr_o, s_wdata_o
`ifdef RIB_ERR_EN
        , output m_err_o
`endif
    );

    // Environment view: drives requests and slave read data.
    modport master (
        output m_req_i, m_we_i, m_addr_i, m_wdata_i, s_rdata_i,
        input  m_rdata_o, m_ack_o, m_hold_o, s_we_o, s_addr_o, s_wdata_o
`ifdef RIB_ERR_EN
        , input m_err_o
`endif
    );
endinterface

// File: rtl/rib_rr.sv
// Shared-bus RIB interconnect: round-robin arbitration with an optional priority master.
// Define RIB_ERR_EN to flag unmapped accesses on m_err_o alongside the ack.
module rib_rr #(
    parameter int NUM_MASTERS = 3,
    parameter int NUM_SLAVES  = 4,
    parameter int DATA_W      = 32,
    parameter int PRIO_MASTER = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    rib_rr_if.slave     bus
);
    // state   | meaning
    // IDLE    | arbitrate; writes complete this cycle, reads issue the slave address
    // RD_WAIT | return slave read data and ack the latched master; no new grant

    localparam int  MW       = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int  SW       = $clog2(NUM_SLAVES);
    localparam bit  PRIO_EN  = (PRIO_MASTER < NUM_MASTERS);
    localparam int  PRIO_IDX = PRIO_EN ? PRIO_MASTER : 0;

    typedef enum logic {IDLE = 1'b0, RD_WAIT = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [MW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [MW-1:0]   win_q, win_d;
    logic [SW-1:0]   slv_q, slv_d;
    logic            hit_q, hit_d;

    logic            found;
    logic [MW-1:0]   win;
    logic [31:0]     w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic            w_we;
    logic            dec_hit;
    logic [SW-1:0]   dec_slv;
    logic [31:0]     dec_addr;

    logic [NUM_MASTERS-1:0] ack, hold, err;
    logic [NUM_SLAVES-1:0]  s_we;
    logic [31:0]            s_addr;
    logic [DATA_W-1:0]      s_wdata, rdata;

    // Winner: priority master if requesting, else first requester after rr_ptr.
    always_comb begin
        found = 1'b0;
        win   = rr_ptr_q;
        if (PRIO_EN && bus.m_req_i[PRIO_IDX]) begin
            found = 1'b1;
            win   = MW'(PRIO_IDX);
        end else begin
            for (int k = 1; k <= NUM_MASTERS; k++) begin
                if (!found && bus.m_req_i[(int'(rr_ptr_q) + k) % NUM_MASTERS]) begin
                    found = 1'b1;
                    win   = MW'((int'(rr_ptr_q) + k) % NUM_MASTERS);
                end
            end
        end
    end

    always_comb begin
        w_addr   = bus.m_addr_i[32*int'(win) +: 32];
        w_wdata  = bus.m_wdata_i[DATA_W*int'(win) +: DATA_W];
        w_we     = bus.m_we_i[win];
        dec_hit  = 1'b0;
        dec_slv  = '0;
        dec_addr = '0;
        if (w_addr[31:28] == 4'd0) begin
            dec_addr = {20'b0, w_addr[11:0]};
            if (w_addr[15:12] == 4'd0) begin
                dec_hit = 1'b1;
            end else if (w_addr[15:12] == 4'd1) begin
                dec_hit = 1'b1;
                dec_slv = SW'(1);
            end
        end else if (int'(w_addr[31:28]) <= NUM_SLAVES - 2) begin
            dec_hit  = 1'b1;
            dec_slv  = SW'(int'(w_addr[31:28]) + 1);
            dec_addr = {4'b0, w_addr[27:0]};
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        win_d    = win_q;
        slv_d    = slv_q;
        hit_d    = hit_q;
        ack      = '0;
        err      = '0;
        s_we     = '0;
        s_addr   = '0;
        s_wdata  = '0;
        rdata    = '0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    rr_ptr_d = win;
                    s_addr   = dec_hit ? dec_addr : 32'd0;
                    s_wdata  = w_wdata;
                    if (w_we) begin
                        ack[win] = 1'b1;
                        err[win] = ~dec_hit;
                        if (dec_hit) s_we[dec_slv] = 1'b1;
                    end else begin
                        state_d = RD_WAIT;
                        win_d   = win;
                        slv_d   = dec_slv;
                        hit_d   = dec_hit;
                    end
                end
            end
            RD_WAIT: begin
                ack[win_q] = 1'b1;
                err[win_q] = ~hit_q;
                rdata      = hit_q ? bus.s_rdata_i[DATA_W*int'(slv_q) +: DATA_W] : '0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
        hold = bus.m_req_i & ~ack;
        // Reset forces every output low at once, even with requests pending.
        if (!rst_n) begin
            ack     = '0;
            err     = '0;
            hold    = '0;
            s_we    = '0;
            s_addr  = '0;
            s_wdata = '0;
            rdata   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= MW'(NUM_MASTERS - 1);
            win_q    <= '0;
            slv_q    <= '0;
            hit_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            win_q    <= win_d;
            slv_q    <= slv_d;
            hit_q    <= hit_d;
        end
    end

    assign bus.m_ack_o   = ack;
    assign bus.m_hold_o  = hold;
    assign bus.s_we_o    = s_we;
    assign bus.s_addr_o  = s_addr;
    assign bus.s_wdata_o = s_wdata;
    assign bus.m_rdata_o = rdata;
`ifdef RIB_ERR_EN
    assign bus.m_err_o   = err;
`endif

endmodule

// File: tb/tb_rib_rr.sv
// Bench for rib_rr: directed reference vectors, then random traffic against a
// transaction-level model of the arbitration and decode rules.
module tb_rib_rr;
    localparam int NM   = 3;
    localparam int NS   = 4;
    localparam int DW   = 32;
    localparam int PRIO = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rib_rr_if #(.NUM_MASTERS(NM), .NUM_SLAVES(NS), .DATA_W(DW)) bus ();
    rib_rr #(.NUM_MASTERS(NM), .NUM_SLAVES(NS), .DATA_W(DW), .PRIO_MASTER(PRIO))
        dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_chk = 0;
    int n_bad = 0;

    // Environment: pending master transactions and slave read data.
    logic [NM-1:0] p_req, p_we;
    logic [31:0]   p_addr [NM];
    logic [DW-1:0] p_wd   [NM];
    logic [DW-1:0] sr     [NS];

    // Model state and expected outputs.
    bit  md_busy, md_hit;
    int  md_w, md_slv, md_ptr;
    logic [NM-1:0] e_ack, e_hold, e_err;
    logic [NS-1:0] e_we;
    logic [31:0]   e_addr;
    logic [DW-1:0] e_wd, e_rd;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic apply();
        bus.m_req_i = p_req;
        bus.m_we_i  = p_we;
        for (int i = 0; i < NM; i++) begin
            bus.m_addr_i[32*i +: 32]  = p_addr[i];
            bus.m_wdata_i[DW*i +: DW] = p_wd[i];
        end
        for (int j = 0; j < NS; j++) bus.s_rdata_i[DW*j +: DW] = sr[j];
    endtask

    task automatic set_m(input int i, input bit rq, input bit we, input logic [31:0] a,
                         input logic [DW-1:0] d);
        p_req[i] = rq;
        p_we[i]  = we;
        p_addr[i] = a;
        p_wd[i]  = d;
    endtask

    function automatic void decode(input logic [31:0] a, output bit hit, output int slv,
                                   output logic [31:0] loc);
        int r, b;
        r = int'(a >> 28);
        b = int'((a >> 12) % 16);
        hit = 1'b0;
        slv = 0;
        loc = '0;
        if (r == 0) begin
            if (b < 2) begin
                hit = 1'b1;
                slv = b;
                loc = a % 4096;
            end
        end else if (r <= NS - 2) begin
            hit = 1'b1;
            slv = r + 1;
            loc = a % (1 << 28);
        end
    endfunction

    function automatic logic [31:0] rnd_addr();
        logic [31:0] a;
        a = $urandom;
        case ($urandom_range(0, 3))
            0: begin
                a[31:28] = 4'd0;
                a[15:12] = 4'($urandom_range(0, 2));
            end
            1: a[31:28] = 4'($urandom_range(1, NS - 2));
            2: a[31:28] = 4'($urandom_range(NS - 1, 15));
            default: ;
        endcase
        return a;
    endfunction

    task automatic check_outputs(input string p);
        chk({p, "_ack"},   bus.m_ack_o,   e_ack);
        chk({p, "_hold"},  bus.m_hold_o,  e_hold);
        chk({p, "_we"},    bus.s_we_o,    e_we);
        chk({p, "_addr"},  bus.s_addr_o,  e_addr);
        chk({p, "_wdata"}, bus.s_wdata_o, e_wd);
        chk({p, "_rdata"}, bus.m_rdata_o, e_rd);
`ifdef RIB_ERR_EN
        chk({p, "_err"},   bus.m_err_o,   e_err);
`endif
    endtask

    task automatic zero_expect();
        e_ack = '0; e_hold = '0; e_err = '0; e_we = '0;
        e_addr = '0; e_wd = '0; e_rd = '0;
    endtask

    // One cycle of the reference: expected outputs from the current inputs, then advance.
    task automatic model_cycle();
        int w, slv;
        bit hit, got;
        logic [31:0] loc;
        zero_expect();
        if (md_busy) begin
            e_ack[md_w] = 1'b1;
            e_err[md_w] = !md_hit;
            e_rd = md_hit ? sr[md_slv] : '0;
            md_busy = 1'b0;
        end else begin
            got = 1'b0;
            w = 0;
            if (PRIO < NM && p_req[PRIO]) begin
                got = 1'b1;
                w = PRIO;
            end else begin
                for (int k = 1; k <= NM && !got; k++) begin
                    if (p_req[(md_ptr + k) % NM]) begin
                        got = 1'b1;
                        w = (md_ptr + k) % NM;
                    end
                end
            end
            if (got) begin
                md_ptr = w;
                decode(p_addr[w], hit, slv, loc);
                e_addr = hit ? loc : 32'd0;
                e_wd = p_wd[w];
                if (p_we[w]) begin
                    e_ack[w] = 1'b1;
                    e_err[w] = !hit;
                    if (hit) e_we[slv] = 1'b1;
                end else begin
                    md_busy = 1'b1;
                    md_w = w;
                    md_slv = slv;
                    md_hit = hit;
                end
            end
        end
        e_hold = p_req & ~e_ack;
    endtask

    initial begin
        p_req = '0;
        p_we = '0;
        for (int i = 0; i < NM; i++) set_m(i, 1'b1, 1'b1, 32'h0000_1004, DW'($urandom));
        for (int j = 0; j < NS; j++) sr[j] = DW'($urandom);
        apply();

        // Reset held with every master requesting: everything quiet.
        #3;
        zero_expect();
        check_outputs("rst");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // First grant after reset goes to the priority master.
        apply(); #2;
        chk("first_ack", bus.m_ack_o, 3'b010);
        chk("first_we",  bus.s_we_o,  4'b0010);
        @(posedge clk); #1;

        // Only m0 left: it gets the next grant; reference write vector.
        set_m(1, 1'b0, 1'b0, 32'h0, '0);
        set_m(2, 1'b0, 1'b0, 32'h0, '0);
        set_m(0, 1'b1, 1'b1, 32'h0000_1004, 32'hA5A5_0001);
        apply(); #2;
        chk("wr_ack",   bus.m_ack_o,   3'b001);
        chk("wr_we",    bus.s_we_o,    4'b0010);
        chk("wr_addr",  bus.s_addr_o,  32'h0000_0004);
        chk("wr_wdata", bus.s_wdata_o, 32'hA5A5_0001);
        @(posedge clk); #1;

        // Read from s2, with an m1 write arriving during RD_WAIT.
        set_m(0, 1'b1, 1'b0, 32'h1000_0008, 32'h0);
        sr[2] = 32'h1234_5678;
        apply(); #2;
        chk("rd_addr",  bus.s_addr_o, 32'h0000_0008);
        chk("rd_hold",  bus.m_hold_o, 3'b001);
        chk("rd_ack0",  bus.m_ack_o,  3'b000);
        chk("rd_we",    bus.s_we_o,   4'b0000);
        @(posedge clk); #1;
        set_m(1, 1'b1, 1'b1, 32'h0000_0010, 32'h0000_BEEF);
        apply(); #2;
        chk("rd_ack1",  bus.m_ack_o,   3'b001);
        chk("rd_data",  bus.m_rdata_o, 32'h1234_5678);
        chk("cont_hold", bus.m_hold_o, 3'b010);
        chk("cont_we0", bus.s_we_o,    4'b0000);
        @(posedge clk); #1;
        set_m(0, 1'b0, 1'b0, 32'h0, '0);
        apply(); #2;
        chk("cont_ack", bus.m_ack_o,  3'b010);
        chk("cont_we",  bus.s_we_o,   4'b0001);
        chk("cont_addr", bus.s_addr_o, 32'h0000_0010);
        @(posedge clk); #1;

        // Unmapped read: no strobe, ack a cycle later with zero data.
        set_m(1, 1'b0, 1'b0, 32'h0, '0);
        set_m(0, 1'b1, 1'b0, 32'h3000_0000, '0);
        apply(); #2;
        chk("unm_we",   bus.s_we_o,   4'b0000);
        chk("unm_ack0", bus.m_ack_o,  3'b000);
        @(posedge clk); #1;
        apply(); #2;
        chk("unm_ack1", bus.m_ack_o,   3'b001);
        chk("unm_rdata", bus.m_rdata_o, 32'h0);
`ifdef RIB_ERR_EN
        chk("unm_err",  bus.m_err_o,   3'b001);
`endif
        @(posedge clk); #1;

        // Reset during RD_WAIT: no ack for the aborted read.
        set_m(0, 1'b1, 1'b0, 32'h2000_0004, '0);
        apply(); #2;
        chk("abort_hold", bus.m_hold_o, 3'b001);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #2;
        chk("abort_ack",  bus.m_ack_o,   3'b000);
        chk("abort_rd",   bus.m_rdata_o, 32'h0);
        chk("abort_hold0", bus.m_hold_o, 3'b000);

        // Random traffic against the model.
        p_req = '0;
        apply();
        @(posedge clk); #1;
        rst_n = 1'b1;
        md_busy = 1'b0;
        md_ptr = NM - 1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int j = 0; j < NS; j++) sr[j] = DW'($urandom);
            if ($urandom_range(0, 99) == 0) begin
                rst_n = 1'b0;
                apply(); #2;
                zero_expect();
                check_outputs("rrst");
                md_busy = 1'b0;
                md_ptr = NM - 1;
                @(posedge clk); #1;
                rst_n = 1'b1;
                continue;
            end
            apply(); #2;
            model_cycle();
            check_outputs("rnd");
            for (int i = 0; i < NM; i++) begin
                if (e_ack[i]) p_req[i] = 1'b0;
            end
            for (int i = 0; i < NM; i++) begin
                if (!p_req[i] && !(md_busy && md_w == i) && $urandom_range(0, 1) == 1)
                    set_m(i, 1'b1, ($urandom_range(0, 2) != 0), rnd_addr(), DW'($urandom));
            end
            if (md_busy && $urandom_range(0, 7) == 0) p_req[md_w] = 1'b0;
            @(posedge clk); #1;
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
